// File: rtl/ram_store_buffer.sv
// Circular store buffer behind the RAM write-data stage; drains words in write order.
// Optional RAM_STORE_DROP_CNT_EN adds a saturating dropped-write counter on o_drop_cnt.
module ram_store_buffer #(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [SIZE_DATA-1:0]       i_data_wr,
  input  logic                       i_rd_en,
  output logic [SIZE_DATA-1:0]       o_data_rd,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wr_err,
  output logic [15:0]                o_drop_cnt
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [SIZE_DATA-1:0] mem [DEPTH];

  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full_q, empty_q;
  logic [SIZE_DATA-1:0] data_rd_q;
  logic                 rd_valid_q;
  logic                 wr_err_q;
  logic                 wr_acc, rd_acc, wr_drop;

  // Accept decisions use the registered flags, so there is no fall-through.
  assign wr_acc  = i_wr_en && !full_q;
  assign rd_acc  = i_rd_en && !empty_q;
  assign wr_drop = i_wr_en && full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CntW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CntW'(DEPTH));
      empty_q    <= (count_d == '0);
      rd_valid_q <= rd_acc;
      wr_err_q   <= wr_drop;
      if (rd_acc) begin
        data_rd_q <= mem[rd_ptr_q];
      end
    end
  end

  // Storage is intentionally unreset; a location is only read after being written.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= i_data_wr;
    end
  end

`ifdef RAM_STORE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_q <= '0;
    end else if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_data_rd  = data_rd_q;
  assign o_rd_valid = rd_valid_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_wr_err   = wr_err_q;

endmodule
